// File: rtl/cnn_pkg.sv
// Shared CNN types: pixel type, conv1/P1 geometry and pooling state enum.
package cnn_pkg;

    localparam int DATA_W  = 16;
    localparam int C1_W    = 24;
    localparam int C1_H    = 24;
    localparam int P1_SIZE = 144;

    typedef logic signed [DATA_W-1:0] pix_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } pool_state_t;

endpackage

// File: rtl/pool_max4.sv
// Two-level signed comparator tree returning the maximum of four pixels.
module pool_max4
    import cnn_pkg::*;
(
    input  pix_t d0,
    input  pix_t d1,
    input  pix_t d2,
    input  pix_t d3,
    output pix_t y
);

    pix_t m01;
    pix_t m23;

    assign m01 = (d0 > d1) ? d0 : d1;
    assign m23 = (d2 > d3) ? d2 : d3;
    assign y   = (m01 > m23) ? m01 : m23;

endmodule

// File: rtl/pool1_engine.sv
// 2x2 stride-2 max-pool from conv1 memory into P1 memory.
// Define POOL1_RELU_EN to clamp negative pooled values to zero.
module pool1_engine
    import cnn_pkg::*;
#(
    parameter int IN_W   = C1_W,
    parameter int IN_H   = C1_H,
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int IN_AW  = 10,
    parameter int OUT_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [IN_AW-1:0]  rd_addr0,
    output logic [IN_AW-1:0]  rd_addr1,
    output logic [IN_AW-1:0]  rd_addr2,
    output logic [IN_AW-1:0]  rd_addr3,
    input  logic [DATA_W-1:0] rd_data0,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    input  logic [DATA_W-1:0] rd_data3,
    output logic              wr_en,
    output logic [OUT_AW-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int HW = IN_W / 2;
    localparam int HH = IN_H / 2;
    localparam int CW = (HW > 1) ? $clog2(HW) : 1;
    localparam int RW = (HH > 1) ? $clog2(HH) : 1;

    localparam logic [CW-1:0]    LAST_C   = CW'(HW - 1);
    localparam logic [RW-1:0]    LAST_R   = RW'(HH - 1);
    localparam logic [IN_AW-1:0] COL_STEP = IN_AW'(2);
    localparam logic [IN_AW-1:0] ROW_STEP = IN_AW'(IN_W + 2);
    localparam logic [IN_AW-1:0] ROW_OFF  = IN_AW'(IN_W);

    pool_state_t state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [IN_AW-1:0]  a0_q, a0_d;
    logic [IN_AW-1:0]  a1_q, a1_d;
    logic [IN_AW-1:0]  a2_q, a2_d;
    logic [IN_AW-1:0]  a3_q, a3_d;
    logic              rd_en_q, rd_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              drain_q, drain_d;
    logic              v1_q, v1_d;
    logic              wr_en_q, wr_en_d;
    logic [OUT_AW-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    pix_t mx;

    pool_max4 u_max (
        .d0 (rd_data0),
        .d1 (rd_data1),
        .d2 (rd_data2),
        .d3 (rd_data3),
        .y  (mx)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        a0_d    = a0_q;
        rd_en_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        drain_d = drain_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    col_d   = '0;
                    row_d   = '0;
                    a0_d    = '0;
                    rd_en_d = 1'b1;
                end
            end
            RUN: begin
                if (col_q != LAST_C) begin
                    col_d   = col_q + CW'(1);
                    a0_d    = a0_q + COL_STEP;
                    rd_en_d = 1'b1;
                end else if (row_q != LAST_R) begin
                    col_d   = '0;
                    row_d   = row_q + RW'(1);
                    a0_d    = a0_q + ROW_STEP;
                    rd_en_d = 1'b1;
                end else begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end
            end
            DRAIN: begin
                if (drain_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        a1_d = a0_d + IN_AW'(1);
        a2_d = a0_d + ROW_OFF;
        a3_d = a0_d + ROW_OFF + IN_AW'(1);
    end

    // Read data lands one cycle after rd_en; the write follows one cycle later.
    always_comb begin
        v1_d      = rd_en_q;
        wr_en_d   = v1_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (v1_q) begin
            wr_addr_d = wr_en_q ? wr_addr_q + OUT_AW'(1) : '0;
`ifdef POOL1_RELU_EN
            wr_data_d = mx[DATA_W-1] ? '0 : mx;
`else
            wr_data_d = mx;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            a0_q      <= '0;
            a1_q      <= '0;
            a2_q      <= '0;
            a3_q      <= '0;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drain_q   <= 1'b0;
            v1_q      <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            a0_q      <= a0_d;
            a1_q      <= a1_d;
            a2_q      <= a2_d;
            a3_q      <= a3_d;
            rd_en_q   <= rd_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            drain_q   <= drain_d;
            v1_q      <= v1_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_en    = rd_en_q;
    assign rd_addr0 = a0_q;
    assign rd_addr1 = a1_q;
    assign rd_addr2 = a2_q;
    assign rd_addr3 = a3_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_pool1_engine.sv
// Directed bench for pool1_engine with a behavioural 4-port conv1 RAM.
module tb_pool1_engine;

    localparam int N = 144;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [9:0]  rd_addr0, rd_addr1, rd_addr2, rd_addr3;
    logic [15:0] rd_data0, rd_data1, rd_data2, rd_data3;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;

    logic [15:0] mem [0:1023];
    logic [15:0] wr_log [0:255];
    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int d0;

    pool1_engine dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_addr3 (rd_addr3),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .rd_data3 (rd_data3),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data0 <= mem[rd_addr0];
        rd_data1 <= mem[rd_addr1];
        rd_data2 <= mem[rd_addr2];
        rd_data3 <= mem[rd_addr3];
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (wr_en) wr_log[wr_addr] = wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int wbase(input int w);
        return 48 * (w / 12) + 2 * (w % 12);
    endfunction

    function automatic logic [15:0] exp_max(input int w);
        int b;
        logic signed [15:0] m;
        logic signed [15:0] v;
        b = wbase(w);
        m = mem[b];
        v = mem[b+1];  if (v > m) m = v;
        v = mem[b+24]; if (v > m) m = v;
        v = mem[b+25]; if (v > m) m = v;
`ifdef POOL1_RELU_EN
        if (m < 0) m = 0;
`endif
        return m;
    endfunction

    // Called at a negedge; start is sampled at the following posedge (E0).
    task automatic run_check(input bit mid_start, input int abort_at);
        int b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= N + 3; i++) begin
            if (i == abort_at) begin
                d0 = done_cnt;
                @(posedge clk);
                #1 reset = 1'b0;
                #1;
                chk("abort_rd_en", 32'(rd_en), 32'd0);
                chk("abort_wr_en", 32'(wr_en), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_addr0", 32'(rd_addr0), 32'd0);
                repeat (4) @(negedge clk);
                chk("abort_no_done", 32'(done_cnt), 32'(d0));
                chk("abort_idle", 32'({rd_en, wr_en, busy}), 32'd0);
                reset = 1'b1;
                return;
            end
            if (i > 0) @(negedge clk);
            chk("rd_en", 32'(rd_en), 32'(i < N));
            chk("busy", 32'(busy), 32'(i < N + 2));
            chk("done", 32'(done), 32'(i == N + 2));
            chk("wr_en", 32'(wr_en), 32'(i >= 2 && i <= N + 1));
            if (i < N) begin
                b = wbase(i);
                chk("addr0", 32'(rd_addr0), 32'(b));
                chk("addr1", 32'(rd_addr1), 32'(b + 1));
                chk("addr2", 32'(rd_addr2), 32'(b + 24));
                chk("addr3", 32'(rd_addr3), 32'(b + 25));
            end
            if (i >= 2 && i <= N + 1) begin
                chk("wr_addr", 32'(wr_addr), 32'(i - 2));
                chk("wr_data", 32'(wr_data), 32'(exp_max(i - 2)));
            end
            if (mid_start) begin
                if (i == 10 || i == 60) start = 1'b1;
                if (i == 11 || i == 61) start = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 1024; k++) mem[k] = 16'(k);
        repeat (3) @(negedge clk);
        chk("rst_ctl", 32'({busy, done, rd_en, wr_en}), 32'd0);
        chk("rst_rd", 32'({rd_addr0, rd_addr1, rd_addr2}), 32'd0);
        chk("rst_wr", 32'({rd_addr3, wr_addr}), 32'd0);
        chk("rst_wd", 32'(wr_data), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_ctl", 32'({busy, done, rd_en, wr_en}), 32'd0);

        // Run 1: RAM[k]=k, mid-run start pulses must be ignored.
        d0 = done_cnt;
        run_check(1'b1, -1);
        chk("done_once", 32'(done_cnt - d0), 32'd1);
        chk("wr0", 32'(wr_log[0]), 32'd25);
        chk("wr11", 32'(wr_log[11]), 32'd47);
        chk("wr12", 32'(wr_log[12]), 32'd73);
        chk("wr143", 32'(wr_log[143]), 32'd575);

        // Run 2: signed data, started the cycle after the done cycle.
        for (int k = 48; k < 576; k++) mem[k] = 16'($urandom);
        mem[0]  = -16'sd5; mem[1]  = -16'sd3;
        mem[24] = -16'sd9; mem[25] = -16'sd1;
        mem[2]  = -16'sd5; mem[3]  = 16'sd7;
        mem[26] = 16'sd2;  mem[27] = 16'sd7;
        run_check(1'b0, -1);
`ifdef POOL1_RELU_EN
        chk("neg_win", 32'(wr_log[0]), 32'd0);
`else
        chk("neg_win", 32'(wr_log[0]), 32'h0000ffff);
`endif
        chk("tie_win", 32'(wr_log[1]), 32'd7);

        // Run 3: aborted by reset at E0+50, then run 4 restarts at address 0.
        @(negedge clk);
        run_check(1'b0, 50);
        run_check(1'b0, -1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
